// File: rtl/apb_slave_regbank.sv
// APB completer with a bank of word-wide read/write registers.
// Programmable wait states; illegal addresses finish with PSLVERR and no side effects.
module apb_slave_regbank #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    // One extra bit so NUM_REGS == 2^(ADDR_WIDTH-2) still compares correctly.
    localparam logic [ADDR_WIDTH-2:0] NUM_REGS_X = (ADDR_WIDTH-1)'(NUM_REGS);
    localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_STATES);

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    write_q, write_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

    logic                    addr_err;
    logic                    ready;
    logic                    reg_we;

    assign addr_err = (PADDR[1:0] != 2'b00)
                    || ({1'b0, PADDR[ADDR_WIDTH-1:2]} >= NUM_REGS_X);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        reg_we  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    idx_d   = PADDR[2 +: IDX_W];
                    write_d = PWRITE;
                    err_d   = addr_err;
                    wdata_d = PWDATA;
                    cnt_d   = WAIT_INIT;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (PENABLE) begin
                    reg_we  = write_q && !err_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
        end
    end

    // NOTE: the bank is flop-based and must read zero after reset, so every entry is reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[idx_q] <= wdata_q;
        end
    end

    assign ready   = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
    assign PREADY  = ready;
    assign PSLVERR = ready && err_q;
    assign PRDATA  = (ready && !write_q && !err_q) ? regs_q[idx_q] : '0;

endmodule

// File: doc/apb_slave_regbank.md
# apb_slave_regbank

APB completer (slave) holding a bank of word-wide read/write registers, for use as the target behind the AHB-to-APB bridge on the APB side. It decodes PADDR, inserts a parameterised number of wait states via PREADY, and returns read data or commits write data on the completing access cycle. Illegal addresses finish with PSLVERR and no side effects.

## Interface
- ADDR_WIDTH, 32, width of PADDR
- DATA_WIDTH, 32, register and data-bus width
- NUM_REGS, 16, number of registers (1..2^(ADDR_WIDTH-2))
- WAIT_STATES, 1, PREADY-low cycles per access phase (0..15)

- PCLK  in  1  single clock, all logic on rising edge
- PRESETn  in  1  asynchronous, active-low reset
- PSEL  in  1  slave select from APB requester
- PENABLE  in  1  access-phase indicator
- PADDR  in  ADDR_WIDTH  byte address
- PWRITE  in  1  1 = write, 0 = read
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  out  DATA_WIDTH  read data, valid only when PREADY=1 for a read
- PREADY  out  1  transfer-complete indicator
- PSLVERR  out  1  error response, valid only when PREADY=1

## Operation
- Register index = PADDR[ADDR_WIDTH-1:2]. Error if PADDR[1:0] != 0 or index >= NUM_REGS.
- FSM with two states:
  - ST_IDLE: PREADY=0. On PSEL=1 and PENABLE=0 (setup phase): latch PADDR, PWRITE, PWDATA and error flag; load wait counter with WAIT_STATES; go to ST_ACCESS.
  - ST_ACCESS: if counter != 0, decrement, PREADY=0. When counter == 0, PREADY=1.
    - On an edge with PSEL=1, PENABLE=1 and PREADY=1: the transfer completes.
      - Write, no error: reg[index] <= latched data.
      - Then go to ST_IDLE.
    - If PSEL=0 in ST_ACCESS (aborted transfer): go to ST_IDLE, no register update.
- PRDATA = reg[latched index] when in ST_ACCESS, PREADY=1, read and no error; otherwise 0.
- PSLVERR = latched error flag while PREADY=1; otherwise 0.
- Error write: no register changes. Error read: PRDATA=0.
- PENABLE=1 while in ST_IDLE (no setup seen) is ignored. PREADY stays 0.
- Decoded index is fully compared against NUM_REGS. No aliasing onto valid registers.

## Timing
- Reset: PREADY=0, PSLVERR=0, PRDATA=0, state ST_IDLE, counter 0, all registers 0. Reset takes effect immediately, even mid-transfer. A pending write is discarded.
- PREADY, PSLVERR and PRDATA are combinational decodes of registered state only. There is no combinational path from APB inputs.
- Setup phase sampled at edge E1. The access phase begins in the following cycle.
  - PREADY rises WAIT_STATES cycles after the first access-phase cycle.
  - With WAIT_STATES=0, PREADY=1 in the first access cycle (two-cycle transfer).
  - With WAIT_STATES=N, a transfer takes 2+N cycles.
- A write is visible to a read whose setup phase is in the cycle immediately after the write completes.
- Back-to-back transfers: the setup phase in the cycle after completion is accepted with no extra idle cycle.
- The same address and data are latched at setup. Input changes during the access phase do not affect the transfer.

## Test plan
- Reset then read reg 3 (PADDR=0x0C), WAIT_STATES=1 -> PREADY low one cycle then high, PRDATA=0x00000000, PSLVERR=0.
- Write 0xDEADBEEF to 0x08, then read 0x08 back-to-back -> write takes 3 cycles, read returns 0xDEADBEEF, PSLVERR=0 on both.
- Write 0x12345678 to 0x40 (index 16 >= NUM_REGS) and to 0x05 (misaligned) -> PSLVERR=1 with PREADY. Subsequent reads of all 16 registers unchanged. Error read of 0x40 returns 0.
- WAIT_STATES=0 build: write 0xA5A5A5A5 to 0x3C, read it back -> PREADY=1 in first access cycle, each transfer 2 cycles, data 0xA5A5A5A5.
- Start write 0x11111111 to 0x00, deassert PRESETn during the wait cycle -> PREADY=0 immediately. After release, reg 0 reads 0x00000000.
- Drop PSEL during the access phase of a write to 0x04 -> FSM returns to idle, reg 1 unchanged. The next normal transfer completes correctly.
